// File: rtl/i_cache_2way_pkg.sv
// Shared types and defaults for the 2-way instruction cache.
// Geometry defaults follow I_CACHE_INDEX / I_CACHE_OFFSET when defined.
// I_CACHE_STATS_EN enables the hit/miss counters in i_cache_2way.
`ifndef I_CACHE_INDEX
`define I_CACHE_INDEX 6
`endif

`ifndef I_CACHE_OFFSET
`define I_CACHE_OFFSET 2
`endif

package i_cache_2way_pkg;

  localparam int unsigned I_CACHE_INDEX_DEF  = `I_CACHE_INDEX;
  localparam int unsigned I_CACHE_OFFSET_DEF = `I_CACHE_OFFSET;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Prefer an empty way, otherwise take the way the LRU bit points at.
  function automatic logic victim_sel(input logic v0, input logic v1, input logic lru);
    if (!v0)      return 1'b0;
    else if (!v1) return 1'b1;
    else          return lru;
  endfunction

endpackage

// File: rtl/i_cache_2way_way.sv
// One way of the 2-way instruction cache: valid/tag/data arrays with a
// combinational read port and a single write port (word write, tag write
// that also sets valid, and invalidate).
module i_cache_2way_way #(
  parameter int unsigned C_INDEX  = 6,
  parameter int unsigned C_OFFSET = 2,
  parameter int unsigned T_WIDTH  = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_INDEX-1:0]  rd_index,
  input  logic [C_OFFSET-1:0] rd_offset,
  output logic                rd_valid,
  output logic [T_WIDTH-1:0]  rd_tag,
  output logic [31:0]         rd_word,
  input  logic [C_INDEX-1:0]  wr_index,
  input  logic [C_OFFSET-1:0] wr_offset,
  input  logic                wr_word_en,
  input  logic [31:0]         wr_word,
  input  logic                tag_en,
  input  logic [T_WIDTH-1:0]  wr_tag,
  input  logic                inv_en
);

  localparam int unsigned SETS  = 1 << C_INDEX;
  localparam int unsigned WORDS = 1 << C_OFFSET;

  logic [SETS-1:0]    valid;
  logic [T_WIDTH-1:0] tags [SETS];
  logic [31:0]        data [SETS][WORDS];

  // Combinational lookup at the requested set/word.
  always_comb begin
    rd_valid = valid[rd_index];
    rd_tag   = tags[rd_index];
    rd_word  = data[rd_index][rd_offset];
  end

  // Valid bits: cleared on reset or invalidate, set when the tag is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (inv_en) begin
      valid[wr_index] <= 1'b0;
    end else if (tag_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (tag_en) tags[wr_index] <= wr_tag;
    if (wr_word_en) data[wr_index][wr_offset] <= wr_word;
  end

endmodule

// File: rtl/i_cache_2way.sv
// 2-way set-associative instruction cache with 1-bit LRU per set and a
// burst refill FSM. Hits return combinationally; misses refill a whole line
// (word 0 upward) and then hit on re-lookup.
// Optional: I_CACHE_STATS_EN adds hit_cnt / miss_cnt outputs.
module i_cache_2way
  import i_cache_2way_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned C_INDEX  = I_CACHE_INDEX_DEF,
  parameter int unsigned C_OFFSET = I_CACHE_OFFSET_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic               p_strobe,
  input  logic               p_flush,
  output logic [31:0]        p_din,
  output logic               p_ready,
  output logic               cache_miss,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready
`ifdef I_CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int unsigned T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int unsigned SETS    = 1 << C_INDEX;

  // Address decode
  logic [C_OFFSET-1:0] offset;
  logic [C_INDEX-1:0]  index;
  logic [T_WIDTH-1:0]  tag;
  logic                unused_byte_bits;

  assign offset           = p_a[C_OFFSET+1:2];
  assign index            = p_a[C_OFFSET+C_INDEX+1:C_OFFSET+2];
  assign tag              = p_a[A_WIDTH-1:C_OFFSET+C_INDEX+2];
  assign unused_byte_bits = &{1'b0, p_a[1:0]};

  // State
  state_t              state, state_n;
  logic [C_OFFSET-1:0] cnt, cnt_n;
  logic                abort, abort_n;
  logic                victim;
  logic [T_WIDTH-1:0]  r_tag;
  logic [C_INDEX-1:0]  r_index;
  logic [SETS-1:0]     lru;

  // Way read/write signals
  logic [1:0]          rd_valid;
  logic [T_WIDTH-1:0]  rd_tag  [2];
  logic [31:0]         rd_word [2];
  logic [1:0]          wr_word_en;
  logic [1:0]          tag_en;
  logic [1:0]          inv_en;
  logic [C_INDEX-1:0]  wr_index;

  logic hit0, hit1, hit;
  logic victim_new;
  logic enter, beat_wr, done, hit_upd;

  assign hit0       = rd_valid[0] && (rd_tag[0] == tag);
  assign hit1       = rd_valid[1] && (rd_tag[1] == tag);
  assign hit        = hit0 || hit1;
  assign victim_new = victim_sel(rd_valid[0], rd_valid[1], lru[index]);

  // Pipeline-facing and memory-facing outputs
  always_comb begin
    p_ready    = (state == IDLE) && p_strobe && hit && !p_flush;
    p_din      = hit0 ? rd_word[0] : rd_word[1];
    cache_miss = p_strobe && !hit;
    m_strobe   = (state == REFILL);
    m_a        = {r_tag, r_index, cnt, 2'b00};
    hit_upd    = p_ready;
  end

  // Next-state logic for the refill FSM
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    abort_n = abort;
    enter   = 1'b0;
    beat_wr = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (p_strobe && !hit && !p_flush) begin
          state_n = REFILL;
          cnt_n   = '0;
          abort_n = 1'b0;
          enter   = 1'b1;
        end
      end
      REFILL: begin
        if (m_ready) begin
          if (abort || p_flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            abort_n = 1'b0;
          end else begin
            beat_wr = 1'b1;
            cnt_n   = cnt + 1'b1;
            if (cnt == '1) begin
              done    = 1'b1;
              state_n = IDLE;
              cnt_n   = '0;
            end
          end
        end else if (p_flush) begin
          abort_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Way write steering: invalidate happens in IDLE at the lookup index,
  // fills and tag commit happen in REFILL at the latched index.
  always_comb begin
    wr_index   = (state == IDLE) ? index : r_index;
    wr_word_en = '0;
    tag_en     = '0;
    inv_en     = '0;
    wr_word_en[victim]   = beat_wr;
    tag_en[victim]       = done;
    inv_en[victim_new]   = enter;
  end

  // FSM registers, refill target latch and LRU bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      abort   <= 1'b0;
      victim  <= 1'b0;
      r_tag   <= '0;
      r_index <= '0;
      lru     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      abort <= abort_n;
      if (enter) begin
        victim  <= victim_new;
        r_tag   <= tag;
        r_index <= index;
      end
      if (hit_upd) lru[index] <= hit0;
      if (done) lru[r_index] <= ~victim;
    end
  end

`ifdef I_CACHE_STATS_EN
  // Hit/miss statistics, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_upd) hit_cnt <= hit_cnt + 32'd1;
      if (enter) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  i_cache_2way_way #(
    .C_INDEX  (C_INDEX),
    .C_OFFSET (C_OFFSET),
    .T_WIDTH  (T_WIDTH)
  ) u_way0 (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index),
    .rd_offset  (offset),
    .rd_valid   (rd_valid[0]),
    .rd_tag     (rd_tag[0]),
    .rd_word    (rd_word[0]),
    .wr_index   (wr_index),
    .wr_offset  (cnt),
    .wr_word_en (wr_word_en[0]),
    .wr_word    (m_dout),
    .tag_en     (tag_en[0]),
    .wr_tag     (r_tag),
    .inv_en     (inv_en[0])
  );

  i_cache_2way_way #(
    .C_INDEX  (C_INDEX),
    .C_OFFSET (C_OFFSET),
    .T_WIDTH  (T_WIDTH)
  ) u_way1 (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index),
    .rd_offset  (offset),
    .rd_valid   (rd_valid[1]),
    .rd_tag     (rd_tag[1]),
    .rd_word    (rd_word[1]),
    .wr_index   (wr_index),
    .wr_offset  (cnt),
    .wr_word_en (wr_word_en[1]),
    .wr_word    (m_dout),
    .tag_en     (tag_en[1]),
    .wr_tag     (r_tag),
    .inv_en     (inv_en[1])
  );

endmodule

// File: tb/tb_i_cache_2way.sv
// Scoreboard bench for i_cache_2way (C_INDEX=6, C_OFFSET=2).
// Memory model returns word = address, m_ready one cycle after m_strobe.
module tb_i_cache_2way;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_a;
  logic        p_strobe;
  logic        p_flush;
  logic [31:0] p_din;
  logic        p_ready;
  logic        cache_miss;
  logic [31:0] m_a;
  logic        m_strobe;
  logic [31:0] m_dout;
  logic        m_ready = 1'b0;
`ifdef I_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  i_cache_2way #(
    .A_WIDTH  (32),
    .C_INDEX  (6),
    .C_OFFSET (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_a        (p_a),
    .p_strobe   (p_strobe),
    .p_flush    (p_flush),
    .p_din      (p_din),
    .p_ready    (p_ready),
    .cache_miss (cache_miss),
    .m_a        (m_a),
    .m_strobe   (m_strobe),
    .m_dout     (m_dout),
    .m_ready    (m_ready)
`ifdef I_CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // Memory: data = address, ready one cycle after strobe
  assign m_dout = m_a;
  always @(posedge clk) m_ready <= rst ? 1'b0 : (m_strobe && !m_ready);

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_din_q [$];
  logic [31:0] exp_ma_q  [$];
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented instruction and each refill beat address
  always @(negedge clk) begin
    if (!rst) begin
      if (p_ready) begin
        if (exp_din_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_p_ready: got p_din 0x%08h expected no response", p_din);
        end else begin
          check("p_din", p_din, exp_din_q.pop_front());
        end
      end
      if (m_strobe && m_ready) begin
        if (exp_ma_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got m_a 0x%08h expected no beat", m_a);
        end else begin
          check("m_a", m_a, exp_ma_q.pop_front());
        end
      end
    end
  end

  task automatic check_stats();
`ifdef I_CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
  endtask

  // Full fetch; expected response and refill addresses are queued up front
  task automatic fetch(input logic [31:0] addr, input logic exp_hit);
    logic [31:0] base;
    int n;
    base = addr & ~32'hF;
    exp_din_q.push_back(addr);
    exp_hits++;
    if (!exp_hit) begin
      for (int unsigned i = 0; i < 4; i++) exp_ma_q.push_back(base + 4 * i);
      exp_misses++;
    end
    p_a      = addr;
    p_strobe = 1'b1;
    @(negedge clk);
    check("cache_miss", 32'(cache_miss), 32'(!exp_hit));
    if (exp_hit) begin
      check("hit_same_cycle", 32'(p_ready), 32'd1);
      check("hit_no_mstrobe", 32'(m_strobe), 32'd0);
    end
    n = 0;
    while (!p_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fetch_done", 32'(p_ready), 32'd1);
    if (!exp_hit) check("miss_latency", 32'(n), 32'd9);
    @(posedge clk);
    #1 p_strobe = 1'b0;
    check("beats_drained", 32'(exp_ma_q.size()), 32'd0);
  endtask

  // Wait (bounded) for the next refill beat at a negedge
  task automatic wait_beat();
    int n;
    n = 0;
    while (!(m_strobe && m_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_seen", 32'(m_strobe && m_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    p_a      = '0;
    p_strobe = 1'b0;
    p_flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_p_ready", 32'(p_ready), 32'd0);
    check("rst_m_strobe", 32'(m_strobe), 32'd0);
    check("rst_cache_miss", 32'(cache_miss), 32'd0);
    check_stats();
    @(posedge clk);
    #1;

    // Cold miss, then hits within the line
    fetch(32'h1000, 1'b0);
    fetch(32'h1008, 1'b1);
    fetch(32'h1004, 1'b1);
    fetch(32'h100C, 1'b1);

    // Flush in IDLE masks a hit and starts nothing
    p_a      = 32'h1004;
    p_strobe = 1'b1;
    p_flush  = 1'b1;
    @(negedge clk);
    check("idle_flush_ready", 32'(p_ready), 32'd0);
    @(posedge clk);
    #1 p_flush = 1'b0;
    p_strobe = 1'b0;
    @(negedge clk);
    check("idle_flush_no_refill", 32'(m_strobe), 32'd0);
    @(posedge clk);
    #1;

    // Same-set replacement: tags 4,5 then 6 evicts LRU (tag 5)
    fetch(32'h1400, 1'b0);
    fetch(32'h1400, 1'b1);
    fetch(32'h1000, 1'b1);
    fetch(32'h1800, 1'b0);
    fetch(32'h1000, 1'b1);
    fetch(32'h1400, 1'b0);
    check_stats();

    // Flush on the second refill beat of 0x2000
    exp_ma_q.push_back(32'h2000);
    exp_ma_q.push_back(32'h2004);
    exp_misses++;
    p_a      = 32'h2000;
    p_strobe = 1'b1;
    @(negedge clk);
    check("flush_cache_miss", 32'(cache_miss), 32'd1);
    wait_beat();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 p_flush = 1'b1;
    p_strobe = 1'b0;
    @(negedge clk);
    check("flush_beat2_present", 32'(m_strobe && m_ready), 32'd1);
    @(posedge clk);
    #1 p_flush = 1'b0;
    @(negedge clk);
    check("flush_mstrobe_off", 32'(m_strobe), 32'd0);
    check("flush_no_ready", 32'(p_ready), 32'd0);
    check("flush_beats_drained", 32'(exp_ma_q.size()), 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h2000, 1'b0);
    fetch(32'h1000, 1'b0);
    fetch(32'h1000, 1'b1);
    check_stats();

    // Reset in the middle of a refill
    exp_ma_q.push_back(32'h3010);
    p_a      = 32'h3010;
    p_strobe = 1'b1;
    @(negedge clk);
    wait_beat();
    @(posedge clk);
    #1 rst = 1'b1;
    p_strobe = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    check("rst_mid_mstrobe", 32'(m_strobe), 32'd0);
    check("rst_mid_ready", 32'(p_ready), 32'd0);
    check_stats();
    @(posedge clk);
    #1;
    fetch(32'h1000, 1'b0);
    fetch(32'h1008, 1'b1);
    check_stats();

    repeat (2) @(posedge clk);
    check("din_queue_drained", 32'(exp_din_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
